// File: rtl/reg_pipe.sv
// Elastic register pipeline: DEPTH registered stages with per-stage valid bits,
// valid/ready on both sides, bubble collapsing, occupancy count and flush.
module reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  logic [DEPTH-1:0] vld_r;
  logic [WIDTH-1:0] dat_r [DEPTH];
  logic [CW-1:0]    count_r;
  logic [DEPTH-1:0] adv_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             accept_s;
  logic             xfer_s;

  // Advance chain: a stage moves when the stage ahead is empty or moving itself.
  always_comb begin : adv_chain
    logic carry_s;
    adv_s            = {DEPTH{1'b0}};
    carry_s          = vld_r[DEPTH-1] & out_ready;
    adv_s[DEPTH-1]   = carry_s;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      carry_s  = vld_r[i] & (~vld_r[i+1] | carry_s);
      adv_s[i] = carry_s;
    end
  end

  // Handshake qualifiers; reset forces ready low, flush blocks both transfers.
  always_comb begin
    in_ready_s  = reset & ~flush & (~vld_r[0] | adv_s[0]);
    out_valid_s = vld_r[DEPTH-1] & ~flush;
    accept_s    = in_valid & in_ready_s;
    xfer_s      = out_valid_s & out_ready;
  end

  // Stage registers: data only changes when a stage is loaded, so a stalled
  // output word is held stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        dat_r[i] <= {WIDTH{1'b0}};
      end
    end else if (flush) begin
      vld_r <= {DEPTH{1'b0}};
    end else begin
      if (accept_s) begin
        vld_r[0] <= 1'b1;
        dat_r[0] <= in_data;
      end else if (adv_s[0]) begin
        vld_r[0] <= 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv_s[i-1]) begin
          vld_r[i] <= 1'b1;
          dat_r[i] <= dat_r[i-1];
        end else if (adv_s[i]) begin
          vld_r[i] <= 1'b0;
        end
      end
    end
  end

  // Occupancy: net change of one accept and one output transfer per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else if (flush) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({accept_s, xfer_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = dat_r[DEPTH-1];
  assign count     = count_r;

endmodule

// File: doc/reg_pipe.md
# reg_pipe

Parametrised elastic register pipeline: a WIDTH-bit, DEPTH-stage chain of registers with per-stage valid bits, a valid/ready handshake on both sides, bubble collapsing, an occupancy count and a synchronous flush. It is the general-purpose successor to the team's single 8-bit storage register. It is used wherever a datapath needs configurable registered delay with back-pressure instead of a free-running latch.

## Interface
- WIDTH, 8, data width in bits; legal range ≥1.
- DEPTH, 4, number of register stages; legal range ≥1.
- CW, $clog2(DEPTH+1), derived width of `count`; not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset: low clears all state immediately; release is synchronous to clk.
- flush  in  1  synchronous clear of all stage valid bits.
- in_valid  in  1  upstream word present.
- in_ready  out  1  pipeline accepts a word this cycle.
- in_data  in  WIDTH  upstream word.
- out_valid  out  1  output stage holds a valid word.
- out_ready  in  1  downstream accepts the output word this cycle.
- out_data  out  WIDTH  output stage word.
- count  out  CW  number of valid stages, 0..DEPTH.

## Operation
- State per stage i (0 = input end, DEPTH-1 = output end): vld[i], dat[i].
- Reset (reset=0): all vld=0, dat=0, count=0. While reset is low, out_valid=0, out_data=0 and in_ready=0.
- Output: out_valid = vld[DEPTH-1] && !flush. out_data = dat[DEPTH-1], which is registered with no combinational path from in_data.
- Advance: adv[DEPTH-1] = vld[DEPTH-1] && out_ready. For i<DEPTH-1, adv[i] = vld[i] && (!vld[i+1] || adv[i+1]).
- in_ready = !flush && (!vld[0] || adv[0]). Ready is a combinational chain from out_ready.
- Bubble collapsing: a valid word always moves into an empty stage ahead of it, even when out_ready=0.
- On a rising edge without flush, each stage i>0 loads dat[i-1] and vld[i]=1 when adv[i-1]. Otherwise it clears vld[i] if adv[i], or holds.
- Stage 0 loads in_data with vld[0]=1 on in_valid && in_ready. Otherwise it clears on adv[0], or holds.
- Hold rule: dat[i] changes only when stage i is loaded. While out_valid && !out_ready, out_data is stable.
- count updates next edge: +1 on accept only, −1 on output transfer only, unchanged on both or neither.
- Flush: on the edge where flush=1, all vld ← 0 and count ← 0. dat is not cleared. During the flush cycle no accept and no output transfer occur. Flush dominates in_valid and out_ready.
- Full: count==DEPTH. in_ready=1 only if out_ready=1 that cycle.
- Empty: count==0, out_valid=0.

## Timing
- Latency: a word accepted in cycle T appears with out_valid=1 in cycle T+DEPTH when there is no back-pressure. For DEPTH=1 that is T+1.
- Throughput: 1 word/cycle sustained when out_ready is held high, including when the pipeline is full.
- in_ready depends combinationally on out_ready, flush and vld only. It must not depend on in_valid.
- out_valid/out_data depend on registers only, plus the flush gate on out_valid.
- Asynchronous reset assertion mid-transfer discards all words. The first accept is possible in the first cycle after release.

## Test plan
- DEPTH=4, WIDTH=8, out_ready=1: send 0x11,0x22,0x33 on consecutive cycles from T=0 -> out_valid in cycles 4,5,6 with 0x11,0x22,0x33; count peaks at 3.
- Fill with out_ready=0: send 0xA0..0xA5 -> exactly 4 accepted (0xA0..0xA3), in_ready=0 after, count=4, out_data=0xA0 held stable. Raise out_ready -> 0xA0..0xA3 drain in order, one per cycle.
- Full plus simultaneous accept and drain: count=4, in_valid=1, out_ready=1 for 10 cycles -> in_ready=1 throughout, count stays 4, output order matches input order.
- Bubble collapse: accept 0x01, then idle 2 cycles, then 0x02, with out_ready=0 -> after settling, both words sit in stages 3 and 2 with count=2. Release out_ready -> 0x01 then 0x02 on consecutive cycles.
- Flush: count=3, assert flush with in_valid=1 and out_ready=1 -> in_ready=0 and out_valid=0 that cycle, next cycle count=0, out_valid=0, and the in_data of the flush cycle is not accepted.
- Async reset mid-stream: drop reset between clock edges while count=2 -> out_valid=0, count=0 and out_data=0 immediately. After release, the first word accepted emerges DEPTH cycles later.
